fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction ROM. Holds the program counter, drives the ROM address, and registers the returned instruction word into a one-entry fetch register with a valid flag for the decoder. Handles start and halt sequencing, stall, and branch redirect with wrong-path flush.

## Interface
- `A`, default 10: instruction address width. The ROM holds 2**A words.
- `W`, default 9: instruction word width.
- `HALT_WORD`, default all ones (`{W{1'b1}}`): encoding that terminates the program.

Ports:
- `Clk`  in  1  sole clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  level; sampled in IDLE or HALT to launch the program at address 0.
- `Stall`  in  1  holds the PC and the fetch register.
- `BranchEn`  in  1  redirect request from downstream for the instruction currently in the fetch register.
- `BranchTarget`  in  A  absolute redirect address.
- `InstIn`  in  W  combinational ROM data for `InstAddress`.
- `InstAddress`  out  A  current PC, driven straight from the PC register.
- `Inst`  out  W  registered instruction.
- `InstValid`  out  1  `Inst` is valid this cycle.
- `InstPc`  out  A  address that `Inst` was fetched from.
- `Done`  out  1  program has halted.
- `CycleCount`  out  16  RUN cycles (see Configuration).
- `InstCount`  out  16  instructions delivered (see Configuration).

## Operation
- States: IDLE, RUN, HALT. Reset enters IDLE.
- Reset values: PC=0, `Inst`=0, `InstValid`=0, `InstPc`=0, `Done`=0, counters=0.
- **IDLE**
  - With `Start`=1: go to RUN, PC=0.
  - Otherwise hold.
- **RUN**, priority high to low:
  1. `BranchEn`=1: PC←`BranchTarget` and `InstValid`←0 (flush the wrong-path word). Overrides `Stall` and halt detection.
  2. `Stall`=1: PC, `Inst`, `InstPc` and `InstValid` all hold.
  3. `InstIn`==`HALT_WORD`: go to HALT; `InstValid`←0; PC holds; the halt word is never presented on `Inst`.
  4. Otherwise: `Inst`←`InstIn`, `InstPc`←PC, `InstValid`←1, PC←PC+1 modulo 2**A (2**A−1 wraps to 0).
- `Start` is ignored in RUN.
- **HALT**
  - `Done`=1, `InstValid`=0, PC frozen.
  - `Start`=1: go to RUN with PC=0 and `Done`←0.
  - `BranchEn` and `Stall` are ignored in HALT and IDLE.
- `Reset` mid-RUN: all state returns to reset values on that edge; any in-flight instruction is dropped.

## Timing
- ROM read is combinational: `InstIn` is expected in the same cycle as `InstAddress`.
- `Start` sampled at edge n: RUN and `InstAddress`=0 from edge n. `Inst`=ROM[0] with `InstValid`=1 from edge n+1.
- Steady state is one instruction per cycle.
- Taken branch at edge n: `InstValid`=0 for the cycle after edge n; `Inst`=ROM[target] from edge n+1. One-cycle bubble.
- Halt word fetched at edge n: `Done`=1 from edge n. The previous instruction's `InstValid` drops at the same edge.
- `Done` and `InstValid` are never 1 together.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `CycleCount` increments every RUN cycle, including stalls.
  - `InstCount` increments on every edge that loads `InstValid`=1 with a new word.
  - Both saturate at 16'hFFFF.
  - Both clear on `Reset` and on the `Start` that leaves IDLE or HALT.
  - Both hold in HALT.
- `FETCH_PERF_CNT_EN` undefined: both ports tied to 0 and no counter flops.

## Test plan
- **Straight line:** ROM = {0x001, 0x002, 0x003, 0x1FF}, pulse `Start` → `Inst` shows 0x001/0x002/0x003 with `InstPc` 0/1/2 on consecutive cycles, then `Done`=1. With the macro, `InstCount`=3.
- **Branch:** take a branch while `Inst` is at address 1 with `BranchTarget`=0x200 → one bubble cycle with `InstValid`=0, then `InstPc`=0x200 carrying ROM[0x200].
- **Branch with stall:** `BranchEn` and `Stall` both high → redirect still taken. A 3-cycle `Stall` alone → `Inst`/`InstPc` frozen for 3 cycles with `InstValid` held, no address skipped.
- **Wrap:** branch to 0x3FF holding a non-halt word → next `InstPc`=0x000.
- **Halt on wrong path:** halt word at the address after a taken branch → branch wins and `Done` stays 0.
- **Reset mid-run:** `Reset` mid-RUN → next cycle IDLE, PC=0, `InstValid`=0, `Done`=0. A restart from HALT via `Start` → `Inst`=ROM[0] two edges later.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM address, one-entry fetch register, start/halt/branch control.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int                A         = 10,
    parameter int                W         = 9,
    parameter logic [W-1:0]      HALT_WORD = {W{1'b1}}
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Stall,
    input  logic         BranchEn,
    input  logic [A-1:0] BranchTarget,
    input  logic [W-1:0] InstIn,
    output logic [A-1:0] InstAddress,
    output logic [W-1:0] Inst,
    output logic         InstValid,
    output logic [A-1:0] InstPc,
    output logic         Done,
    output logic [15:0]  CycleCount,
    output logic [15:0]  InstCount
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t         r_state;
    logic [A-1:0]   r_pc;
    logic [W-1:0]   r_inst;
    logic [A-1:0]   r_inst_pc;
    logic           r_valid;
    logic           r_done;

    logic           w_run;
    logic           w_launch;
    logic           w_redirect;
    logic           w_halt_word;
    logic           w_halt;
    logic           w_load;

    assign w_run       = (r_state == S_RUN);
    assign w_launch    = !w_run && Start;
    assign w_redirect  = w_run && BranchEn;
    assign w_halt_word = (InstIn == HALT_WORD);
    // Branch beats stall and halt; stall beats halt.
    assign w_halt      = w_run && !BranchEn && !Stall && w_halt_word;
    assign w_load      = w_run && !BranchEn && !Stall && !w_halt_word;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_inst    <= '0;
            r_inst_pc <= '0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_state <= S_RUN;
                        r_pc    <= '0;
                    end
                end
                S_RUN: begin
                    if (w_redirect) begin
                        r_pc    <= BranchTarget;
                        r_valid <= 1'b0;
                    end else if (w_halt) begin
                        r_state <= S_HALT;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_load) begin
                        r_inst    <= InstIn;
                        r_inst_pc <= r_pc;
                        r_valid   <= 1'b1;
                        r_pc      <= r_pc + {{(A-1){1'b0}}, 1'b1};
                    end
                end
                S_HALT: begin
                    if (Start) begin
                        r_state <= S_RUN;
                        r_pc    <= '0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign InstAddress = r_pc;
    assign Inst        = r_inst;
    assign InstValid   = r_valid;
    assign InstPc      = r_inst_pc;
    assign Done        = r_done;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_cycle_cnt;
    logic [15:0] r_inst_cnt;

    always_ff @(posedge Clk) begin
        if (Reset || w_launch) begin
            r_cycle_cnt <= '0;
            r_inst_cnt  <= '0;
        end else begin
            if (w_run && (r_cycle_cnt != 16'hFFFF))
                r_cycle_cnt <= r_cycle_cnt + 16'd1;
            if (w_load && (r_inst_cnt != 16'hFFFF))
                r_inst_cnt <= r_inst_cnt + 16'd1;
        end
    end

    assign CycleCount = r_cycle_cnt;
    assign InstCount  = r_inst_cnt;
`else
    assign CycleCount = 16'd0;
    assign InstCount  = 16'd0;
`endif

endmodule
